// File: rtl/synth_pkg.sv
// Shared MIDI constants, queue entry layout and sequencer states for the
// synth-to-MIDI output path.
package synth_pkg;

    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
    localparam logic [7:0] MIDI_PROG_CHG = 8'hC0;
    localparam logic [6:0] NOTE_OFF_VEL  = 7'h40;

    localparam int PITCH_W = 7;
    localparam int VOL_W   = 7;
    localparam int INST_W  = 4;

    typedef struct packed {
        logic               on;
        logic [PITCH_W-1:0] pitch;
        logic [VOL_W-1:0]   vol;
        logic [INST_W-1:0]  inst;
    } midiEvent_t;

    typedef enum logic [2:0] {
        IDLE, POP, PC_STATUS, PC_DATA, NOTE_STATUS, NOTE_KEY, NOTE_VEL
    } seqState_t;

    function automatic logic [7:0] noteStatus(input logic on, input logic [3:0] ch);
        return (on ? MIDI_NOTE_ON : MIDI_NOTE_OFF) | {4'h0, ch};
    endfunction

endpackage

// File: rtl/synth_uart_tx.sv
// 8N1 byte serializer. oBusy drops during the final stop-bit cycle so the
// next byte can be loaded and its start bit follows with no idle gap.
module synth_uart_tx #(
    parameter int DIV = 1600
)(
    input  logic       CLK,
    input  logic       iRST_n,
    input  logic [7:0] iData,
    input  logic       iStart,
    output logic       oBusy,
    output logic       oTx
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          active;
    logic [9:0]    shifter;
    logic [3:0]    bitCnt;
    logic [CW-1:0] divCnt;
    logic          bitEnd;
    logic          lastCycle;

    assign bitEnd    = (divCnt == CW'(DIV - 1));
    assign lastCycle = active && bitEnd && (bitCnt == 4'd9);
    assign oBusy     = active && !lastCycle;
    // Line is forced idle whenever no frame is active, including during reset.
    assign oTx       = active ? shifter[0] : 1'b1;

    always_ff @(posedge CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            active  <= 1'b0;
            shifter <= '1;
            bitCnt  <= '0;
            divCnt  <= '0;
        end else if (iStart && !oBusy) begin
            active  <= 1'b1;
            shifter <= {1'b1, iData, 1'b0};
            bitCnt  <= '0;
            divCnt  <= '0;
        end else if (active) begin
            if (bitEnd) begin
                divCnt  <= '0;
                bitCnt  <= bitCnt + 4'd1;
                shifter <= {1'b1, shifter[9:1]};
                if (bitCnt == 4'd9)
                    active <= 1'b0;
            end else begin
                divCnt <= divCnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/synth_midi_out.sv
// Turns synth controller note/volume/instrument changes into MIDI program
// change and note on/off messages on a 31.25 kbaud serial line.
module synth_midi_out
    import synth_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 31250,
    parameter int MIDI_CH    = 0,
    parameter int FIFO_DEPTH = 8
)(
    input  logic                          CLK,
    input  logic                          iRST_n,
    input  logic [7:0]                    iSynth,
    input  logic [6:0]                    iSynthVolume,
    input  logic [3:0]                    iSynthInst,
    output logic                          oMidiTx,
    output logic                          oBusy,
    output logic                          oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoLevel
);

    localparam int              DIV      = CLK_HZ / BAUD;
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0]      CH       = 4'(MIDI_CH);
    localparam logic [AW:0]     FULL_LVL = (AW+1)'(FIFO_DEPTH);

    midiEvent_t raw, sync1, sync2, stab, lastAcc;
    logic       evt;

    assign raw = {iSynth[0], iSynth[7:1], iSynthVolume, iSynthInst};
    assign evt = (sync2 == stab) && (sync2 != lastAcc);

    // While reset is held lastAcc tracks the input, so a steady bundle across
    // reset release never looks like a new event.
    always_ff @(posedge CLK) begin
        sync1 <= raw;
        sync2 <= sync1;
        stab  <= sync2;
        if (!iRST_n || evt)
            lastAcc <= sync2;
    end

    midiEvent_t  mem [FIFO_DEPTH];
    midiEvent_t  head;
    logic [AW:0] wrCnt, rdCnt, level;
    logic        full, empty, pop, pushOk;

    assign level  = wrCnt - rdCnt;
    assign full   = (level == FULL_LVL);
    assign empty  = (level == '0);
    assign pushOk = evt && (!full || pop);
    assign head   = mem[rdCnt[AW-1:0]];

    // A full queue popped this cycle still accepts: the pop reads the old head
    // combinationally, the write lands on that same slot at the edge.
    always_ff @(posedge CLK) begin
        if (pushOk)
            mem[wrCnt[AW-1:0]] <= sync2;
    end

    always_ff @(posedge CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wrCnt     <= '0;
            rdCnt     <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (pushOk)
                wrCnt <= wrCnt + (AW+1)'(1);
            if (pop)
                rdCnt <= rdCnt + (AW+1)'(1);
            if (evt && !pushOk)
                oOverflow <= 1'b1;
        end
    end

    seqState_t  state, nextState;
    midiEvent_t cur;
    logic [3:0] lastInst;
    logic       lastInstValid;
    logic       needPc;
    logic       txStart, txBusy;
    logic [7:0] txData;

    assign needPc = !lastInstValid || (head.inst != lastInst);

    always_ff @(posedge CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state         <= IDLE;
            cur           <= '0;
            lastInst      <= '0;
            lastInstValid <= 1'b0;
        end else begin
            state <= nextState;
            if (state == POP)
                cur <= head;
            if (state == PC_DATA && !txBusy) begin
                lastInst      <= cur.inst;
                lastInstValid <= 1'b1;
            end
        end
    end

    // Each byte state covers the byte currently on the line; the next byte is
    // launched in the serializer's last stop-bit cycle.
    always_comb begin
        nextState = state;
        pop       = 1'b0;
        txStart   = 1'b0;
        txData    = 8'h00;
        case (state)
            IDLE:
                if (!empty && !txBusy)
                    nextState = POP;
            POP: begin
                pop     = 1'b1;
                txStart = 1'b1;
                if (needPc) begin
                    txData    = MIDI_PROG_CHG | {4'h0, CH};
                    nextState = PC_STATUS;
                end else begin
                    txData    = noteStatus(head.on, CH);
                    nextState = NOTE_STATUS;
                end
            end
            PC_STATUS:
                if (!txBusy) begin
                    txStart   = 1'b1;
                    txData    = {4'h0, cur.inst};
                    nextState = PC_DATA;
                end
            PC_DATA:
                if (!txBusy) begin
                    txStart   = 1'b1;
                    txData    = noteStatus(cur.on, CH);
                    nextState = NOTE_STATUS;
                end
            NOTE_STATUS:
                if (!txBusy) begin
                    txStart   = 1'b1;
                    txData    = {1'b0, cur.pitch};
                    nextState = NOTE_KEY;
                end
            NOTE_KEY:
                if (!txBusy) begin
                    txStart   = 1'b1;
                    txData    = cur.on ? {1'b0, cur.vol} : {1'b0, NOTE_OFF_VEL};
                    nextState = NOTE_VEL;
                end
            NOTE_VEL:
                if (!txBusy)
                    nextState = IDLE;
            default:
                nextState = IDLE;
        endcase
    end

    synth_uart_tx #(.DIV(DIV)) uTx (
        .CLK    (CLK),
        .iRST_n (iRST_n),
        .iData  (txData),
        .iStart (txStart),
        .oBusy  (txBusy),
        .oTx    (oMidiTx)
    );

    assign oBusy      = (state != IDLE);
    assign oFifoLevel = level;

endmodule
